// File: rtl/c432_key_loader.sv
// rtl/c432_key_loader.sv - serial key loader committing atomic keys to the c432 core
//
// Optional feature macro: C432_KEY_PARITY_EN (adds one trailing even-parity bit).
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   start          in   begin a load from IDLE (level-sampled)
//   clear          in   abort a load / clear a committed key
//   key_bit_in     in   serial key bit, LSB first
//   key_bit_valid  in   key_bit_in valid
//   key_bit_ready  out  loader accepts a bit this cycle
//   key_out        out  committed key to the core (bit 0 drives D_0)
//   key_valid      out  key_out holds a committed key
//   busy           out  high while loading or committing
//   err            out  sticky abort flag (timeout or parity)

module c432_key_loader #(
    parameter int KEY_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic             key_bit_in,
    input  logic             key_bit_valid,
    output logic             key_bit_ready,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(KEY_W + 1);
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
`ifdef C432_KEY_PARITY_EN
        S_PARITY,
`endif
        S_COMMIT,
        S_DONE
    } state_t;

    state_t           state;
    logic [KEY_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic [TMR_W-1:0] timer;
    logic             xfer;

    assign xfer = key_bit_valid & key_bit_ready;

    // key_bit_ready and busy are registered alongside each state change so
    // they always reflect the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            shadow        <= '0;
            cnt           <= '0;
            timer         <= '0;
            key_out       <= '0;
            key_valid     <= 1'b0;
            key_bit_ready <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
        end else if (clear) begin
            // clear outranks start and any same-cycle transfer
            state         <= S_IDLE;
            key_bit_ready <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            if (state == S_DONE) begin
                key_out   <= '0;
                key_valid <= 1'b0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state         <= S_SHIFT;
                        key_bit_ready <= 1'b1;
                        busy          <= 1'b1;
                        shadow        <= '0;
                        cnt           <= '0;
                        timer         <= '0;
                        err           <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (xfer) begin
                        // LSB-first shift: after KEY_W bits the first bit sits in bit 0
                        shadow <= KEY_W'({key_bit_in, shadow} >> 1);
                        cnt    <= cnt + CNT_W'(1);
                        timer  <= '0;
                        if (cnt == CNT_W'(KEY_W - 1)) begin
`ifdef C432_KEY_PARITY_EN
                            state <= S_PARITY;
`else
                            state         <= S_COMMIT;
                            key_bit_ready <= 1'b0;
`endif
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        state         <= S_IDLE;
                        key_bit_ready <= 1'b0;
                        busy          <= 1'b0;
                        err           <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
`ifdef C432_KEY_PARITY_EN
                S_PARITY: begin
                    if (xfer) begin
                        key_bit_ready <= 1'b0;
                        timer         <= '0;
                        if (key_bit_in == ^shadow) begin
                            state <= S_COMMIT;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            err   <= 1'b1;
                        end
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        state         <= S_IDLE;
                        key_bit_ready <= 1'b0;
                        busy          <= 1'b0;
                        err           <= 1'b1;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
`endif
                S_COMMIT: begin
                    key_out   <= shadow;
                    key_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_DONE;
                end
                S_DONE: begin
                    // key locked; only clear or reset leave this state
                end
                default: begin
                    state         <= S_IDLE;
                    key_bit_ready <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule
